clock_gate_ctrl: RTL and testbench
==================================

# clock_gate_ctrl

Run/halt/step sequencer for the processor core clock. Generates a registered clock-enable (`cpu_en`) that the core and its register files qualify every edge with, so the free-running system clock never stops while execution can be halted, single-stepped, or run for an exact number of cycles. Sits between the free-running clock source, the debug/test harness, and the CPU top. It also keeps a count of the enabled cycles.

## Interface
Parameters:
- `CNT_W`, 16: width of the burst length and the burst down-counter.
- `CYC_W`, 32: width of the enabled-cycle counter.

Ports:
- `clk`  in  1  free-running system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run_req`  in  1  level; request free-run.
- `halt_req`  in  1  level; request stop.
- `step_req`  in  1  pulse; request exactly one enabled cycle.
- `burst_req`  in  1  pulse; request `burst_len` enabled cycles.
- `burst_len`  in  CNT_W  burst length, sampled only when `burst_req` is accepted.
- `cpu_en`  out  1  registered clock enable to the core.
- `busy`  out  1  high in any state other than HALTED.
- `done`  out  1  one-cycle pulse when a step or burst completes.
- `cyc_count`  out  CYC_W  total cycles with `cpu_en`=1.
- `brk`  in  1  breakpoint hit. Present only with `CLOCK_GATE_CTRL_BRK_EN`.

## Operation
- There are 4 states: HALTED, RUN, STEP, BURST. Reset sends the block to HALTED.
- From HALTED, requests are taken in this priority order: `halt_req` > `step_req` > `burst_req` > `run_req`.
  - `halt_req` keeps the block in HALTED.
  - `step_req` goes to STEP.
  - `burst_req` with `burst_len`≠0 goes to BURST and loads the counter with `burst_len`.
  - `burst_req` with `burst_len`=0 stays in HALTED and pulses `done` on the next cycle. No enable is issued.
  - `run_req` goes to RUN.
- RUN: `cpu_en`=1 every cycle. `halt_req` goes to HALTED. `step_req`, `burst_req` and `run_req` are ignored.
- STEP: exactly one `cpu_en` cycle, then HALTED with a `done` pulse. `halt_req` arriving in the same cycle as the step still lets that single enabled cycle finish.
- BURST: `cpu_en`=1 while the counter is non-zero. The counter decrements on each enabled cycle. When the counter reaches 1, the block goes to HALTED and pulses `done` in the following cycle. `halt_req` aborts the burst immediately (no further enables) and no `done` is produced.
- `cyc_count` increments on every cycle with `cpu_en`=1 and wraps modulo 2^CYC_W. It is cleared only by `reset`.
- `reset` asserted in the middle of any operation overrides everything on the next edge.

## Timing
- Reset values: `cpu_en`=0, `busy`=0, `done`=0, `cyc_count`=0, state=HALTED, counter=0.
- All outputs are registered. A request sampled at edge N produces `cpu_en`=1 in the cycle starting at edge N+1, so latency is 1 cycle.
- Step: `cpu_en` is high for cycle N+1 only. `done` is high in cycle N+2.
- Burst of L: `cpu_en` is high for cycles N+1..N+L. `done` is high in cycle N+L+1. `busy` is high for cycles N+1..N+L.
- Halt from RUN: `halt_req` sampled at edge M gives `cpu_en`=0 from cycle M+1.
- `done` and `cpu_en` are never high in the same cycle that ends a step or burst.

## Configuration
- `CLOCK_GATE_CTRL_BRK_EN` defined:
  - Adds the `brk` input.
  - `brk`=1 sampled in RUN or BURST behaves like `halt_req`, except that `done` pulses on the next cycle.
  - `brk` is ignored in HALTED and STEP.
- Undefined: the port is absent and the logic compiles out.

## Structure
- `clock_gate_ctrl_pkg`: state enum `cg_state_t` (HALTED, RUN, STEP, BURST) and the default widths.
- Sub-module `burst_counter`: a loadable CNT_W down-counter with load, decrement-enable, and an `is_one` flag.

## Test plan
- Reset, then idle 5 cycles -> `cpu_en`=0, `busy`=0, `cyc_count`=0 throughout.
- `step_req` pulse at cycle 3 -> `cpu_en` high only in cycle 4, `done` in cycle 5, `cyc_count`=1.
- `burst_req` with `burst_len`=5 -> exactly 5 consecutive `cpu_en` cycles, then `done`, `cyc_count`=5. `burst_len`=0 -> no enable, `done` after 1 cycle.
- `run_req` held for 20 cycles, then `halt_req` -> `cpu_en` stops 1 cycle after halt is sampled, `cyc_count`=20, no `done`.
- `halt_req` asserted 2 cycles into a burst of 10 -> 2 enabled cycles only, no `done`. `step_req` and `halt_req` in the same cycle from HALTED -> no enable.
- `CYC_W`=4 with a 18-cycle run -> `cyc_count` wraps to 2. With `CLOCK_GATE_CTRL_BRK_EN`, `brk` in cycle 3 of RUN -> enables stop and `done` pulses.

Source files
------------

// File: rtl/clock_gate_ctrl_pkg.sv
// Shared types and default widths for the run/halt/step clock-enable sequencer.
package clock_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    BURST  = 2'd3
  } cg_state_t;

  localparam int CNT_W_DEF = 16;
  localparam int CYC_W_DEF = 32;

endpackage

// File: rtl/clock_gate_ctrl_burst_counter.sv
// Loadable down-counter that tracks the remaining enabled cycles of a burst.
module burst_counter
  import clock_gate_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt_r;

  // Load has priority over decrement; the counter never wraps below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign is_one = (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/clock_gate_ctrl.sv
// Run/halt/step/burst sequencer producing a registered core clock enable.
// Optional breakpoint input is enabled with CLOCK_GATE_CTRL_BRK_EN.
module clock_gate_ctrl
  import clock_gate_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             burst_req,
  input  logic [CNT_W-1:0] burst_len,
`ifdef CLOCK_GATE_CTRL_BRK_EN
  input  logic             brk,
`endif
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic [CYC_W-1:0] cyc_count
);

  cg_state_t        st_r, nxt_st_s;
  logic             nxt_en_s, nxt_done_s;
  logic             load_s, dec_s, is_one_s, brk_s;
  logic             cpu_en_r, busy_r, done_r;
  logic [CYC_W-1:0] cyc_count_r;

`ifdef CLOCK_GATE_CTRL_BRK_EN
  assign brk_s = brk;
`else
  assign brk_s = 1'b0;
`endif

  burst_counter #(.CNT_W(CNT_W)) u_burst_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .load_val (burst_len),
    .dec      (dec_s),
    .is_one   (is_one_s)
  );

  // Next-state and next-output decode; the enable is computed one cycle ahead.
  always_comb begin
    nxt_st_s   = st_r;
    nxt_en_s   = 1'b0;
    nxt_done_s = 1'b0;
    load_s     = 1'b0;
    dec_s      = 1'b0;
    case (st_r)
      HALTED: begin
        if (halt_req) begin
          nxt_st_s = HALTED;
        end else if (step_req) begin
          nxt_st_s = STEP;
          nxt_en_s = 1'b1;
        end else if (burst_req) begin
          if (burst_len != {CNT_W{1'b0}}) begin
            nxt_st_s = BURST;
            nxt_en_s = 1'b1;
            load_s   = 1'b1;
          end else begin
            nxt_done_s = 1'b1;
          end
        end else if (run_req) begin
          nxt_st_s = RUN;
          nxt_en_s = 1'b1;
        end else begin
          nxt_st_s = HALTED;
        end
      end
      RUN: begin
        if (halt_req || brk_s) begin
          nxt_st_s   = HALTED;
          nxt_done_s = brk_s;
        end else begin
          nxt_en_s = 1'b1;
        end
      end
      // A step always completes its single enabled cycle, even under halt.
      STEP: begin
        nxt_st_s   = HALTED;
        nxt_done_s = 1'b1;
      end
      BURST: begin
        dec_s = 1'b1;
        if (halt_req || brk_s) begin
          nxt_st_s   = HALTED;
          nxt_done_s = brk_s;
        end else if (is_one_s) begin
          nxt_st_s   = HALTED;
          nxt_done_s = 1'b1;
        end else begin
          nxt_en_s = 1'b1;
        end
      end
      default: begin
        nxt_st_s = HALTED;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_r        <= HALTED;
      cpu_en_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cyc_count_r <= {CYC_W{1'b0}};
    end else begin
      st_r        <= nxt_st_s;
      cpu_en_r    <= nxt_en_s;
      busy_r      <= (nxt_st_s != HALTED);
      done_r      <= nxt_done_s;
      cyc_count_r <= cyc_count_r + {{(CYC_W-1){1'b0}}, cpu_en_r};
    end
  end

  assign cpu_en    = cpu_en_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign cyc_count = cyc_count_r;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Table-driven scoreboard bench for clock_gate_ctrl; a second instance with
// CYC_W=4 shares the stimulus to check counter wrap.
module tb_clock_gate_ctrl;

  typedef struct {
    logic        rst;
    logic        run;
    logic        halt;
    logic        step;
    logic        bst;
    logic [15:0] len;
    logic        brk;
    logic        en;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        run_req, halt_req, step_req, burst_req;
  logic [15:0] burst_len;
`ifdef CLOCK_GATE_CTRL_BRK_EN
  logic        brk;
`endif
  logic        cpu_en, busy, done;
  logic [31:0] cyc_count;
  logic        cpu_en4, busy4, done4;
  logic [3:0]  cyc_count4;

  int   n_checks;
  int   n_fail;
  vec_t exp_q[$];
  vec_t tbl[$];

  clock_gate_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .run_req   (run_req),
    .halt_req  (halt_req),
    .step_req  (step_req),
    .burst_req (burst_req),
    .burst_len (burst_len),
`ifdef CLOCK_GATE_CTRL_BRK_EN
    .brk       (brk),
`endif
    .cpu_en    (cpu_en),
    .busy      (busy),
    .done      (done),
    .cyc_count (cyc_count)
  );

  clock_gate_ctrl #(.CYC_W(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .run_req   (run_req),
    .halt_req  (halt_req),
    .step_req  (step_req),
    .burst_req (burst_req),
    .burst_len (burst_len),
`ifdef CLOCK_GATE_CTRL_BRK_EN
    .brk       (brk),
`endif
    .cpu_en    (cpu_en4),
    .busy      (busy4),
    .done      (done4),
    .cyc_count (cyc_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic rst, input logic run, input logic halt,
                              input logic step, input logic bst, input logic [15:0] len,
                              input logic brk_i, input logic en, input logic bsy,
                              input logic dn, input logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.run = run; v.halt = halt; v.step = step; v.bst = bst;
    v.len = len; v.brk = brk_i; v.en = en; v.busy = bsy; v.done = dn; v.cnt = cnt;
    return v;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, expv);
    end
  endtask

  task automatic check_front(input int idx);
    vec_t e;
    e = exp_q.pop_front();
    cmp("cpu_en", idx, {31'd0, cpu_en}, {31'd0, e.en});
    cmp("busy", idx, {31'd0, busy}, {31'd0, e.busy});
    cmp("done", idx, {31'd0, done}, {31'd0, e.done});
    cmp("cyc_count", idx, cyc_count, e.cnt);
    cmp("cyc_count_w4", idx, {28'd0, cyc_count4}, {28'd0, e.cnt[3:0]});
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset     = v.rst;
    run_req   = v.run;
    halt_req  = v.halt;
    step_req  = v.step;
    burst_req = v.bst;
    burst_len = v.len;
`ifdef CLOCK_GATE_CTRL_BRK_EN
    brk       = v.brk;
`endif
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_front(idx);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    burst_req = 1'b0; burst_len = 16'd0;
`ifdef CLOCK_GATE_CTRL_BRK_EN
    brk = 1'b0;
`endif

    //                 rst   run   halt  step  bst   len    brk   en    busy  done  cnt
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
    // single step
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1));
    // burst of 5
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd3));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd4));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd5));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd6));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6));
    // zero-length burst: done only
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd6));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6));
    // step together with halt from HALTED: no enable
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6));
    // halt during the step cycle does not cancel it
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd6));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd7));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd7));
    // step beats burst
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, 1'b0, 1'b1, 1'b1, 1'b0, 32'd7));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd8));
    // burst of 10 aborted after 2 enabled cycles
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd10, 1'b0, 1'b1, 1'b1, 1'b0, 32'd8));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd9));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd10));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd10));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd10));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], i);

    // run held 20 cycles with ignored step/burst in the middle, then halt
    for (int i = 1; i <= 20; i++)
      apply(mk(1'b0, 1'b1, 1'b0, (i == 10) ? 1'b1 : 1'b0, (i == 12) ? 1'b1 : 1'b0, 16'd2,
               1'b0, 1'b1, 1'b1, 1'b0, 32'd10 + 32'(i - 1)), 100 + i);
    apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd30), 121);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd30), 122);

    // reset in the middle of a burst
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4, 1'b0, 1'b1, 1'b1, 1'b0, 32'd30), 130);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd31), 131);
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0), 132);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0), 133);

    // 18-cycle run: narrow counter wraps to 2
    for (int i = 1; i <= 18; i++)
      apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'(i - 1)), 140 + i);
    apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd18), 159);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd18), 160);

`ifdef CLOCK_GATE_CTRL_BRK_EN
    // breakpoint in RUN, in BURST, ignored in HALTED and STEP
    apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd18), 200);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd19), 201);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd20), 202);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd21), 203);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd21), 204);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5, 1'b0, 1'b1, 1'b1, 1'b0, 32'd21), 205);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd22), 206);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd22), 207);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd22), 208);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd22), 209);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd23), 210);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd23), 211);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
